life_keys: RTL
==============

// Module: life_keys
// PURPOSE
//  Front-panel input controller for the life game; drives the life core's keys/cursor inputs.
//  Samples raw pushbuttons, synchronises and debounces them, and turns presses into 1-cycle command codes.
//  Owns the cursor_x/cursor_y registers.
//  Arrow keys auto-repeat while held.
// PARAMETERS
//  X          8   board width (cells)
//  Y          8   board height (cells)
//  LOG2X      3   cursor_x width
//  LOG2Y      3   cursor_y width
//  TICK_W     10  prescaler width; one sample tick every 2**TICK_W clk cycles
//  DEB_TICKS  4   consecutive equal samples needed to accept a level change (>=2)
//  REP_DLY    32  ticks an arrow must be held before the first repeat
//  REP_RATE   8   ticks between subsequent repeats
// PORTS
//  clk       in   1      system clock
//  reset     in   1      synchronous, active-low reset
//  btn_n     in   6      raw buttons, active-low; [0]up [1]down [2]left [3]right [4]set [5]run
//  keys      out  3      command code, valid for exactly 1 cycle, else KEY_NONE
//  cursor_x  out  LOG2X  cursor column, 0..X-1
//  cursor_y  out  LOG2Y  cursor row, 0..Y-1
//  busy      out  1      at least one press event is pending
// BEHAVIOUR
//  Reset (reset==0 at a clk edge) clears all state, including the mid-press debounce/repeat state:
//   - keys=KEY_NONE, cursor_x=0, cursor_y=0, busy=0
//   - prescaler=0, debounced state=released, pending=0, repeat counters=0
//   - buttons held across reset produce no event until released and pressed again.
//  Sync: each btn_n bit passes through 2 flops before use.
//  Prescaler: free-running TICK_W counter; tick=1 for one cycle when it wraps to 0.
//  Debounce (per button, on tick only):
//   - sample != debounced state -> increment counter; else clear counter.
//   - counter reaching DEB_TICKS-1 -> flip debounced state, clear counter.
//  Press event: the debounced released->pressed transition sets pending[i]. Release sets nothing.
//  Auto-repeat (arrows [3:0] only, never set/run):
//   - while pressed, count ticks.
//   - first re-set of pending[i] at REP_DLY, then every REP_RATE.
//   - count clears on release.
//  Issue, every cycle:
//   - if pending!=0, the lowest set index wins.
//   - keys<=code(index), that pending bit is cleared, cursor is updated in the same edge.
//   - one event per cycle; no event is lost when several are pending.
//   - an event set in the same cycle as its bit is issued stays pending (set wins).
//  Codes (key_codes.vh):
//   - NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4, SET=5, RUN=6; 7 is reserved and never driven.
//  Cursor arithmetic is modulo the board, not modulo 2**LOGn:
//   - UP: y==0 -> Y-1, else y-1.  DOWN: y==Y-1 -> 0, else y+1.
//   - LEFT/RIGHT: same rule on x with X.
//   - SET and RUN leave the cursor unchanged.
//  keys is registered: the code appears the cycle after issue and returns to NONE the next cycle,
//   unless another event is issued back-to-back.
//  busy = (pending != 0), registered.
// STRUCTURE
//  Key-code localparams stay in key_codes.vh, shared with the life core; add no new ones.
//  Sub-module key_debounce holds one button's sync, debounce, edge detect and repeat counter.
//   - ports: clk, reset, tick, btn_n, press_evt; repeat enabled by parameter REPEAT.
//   - instantiated 6x, with REPEAT=1 for [3:0].
//  Top level holds the prescaler, pending register, priority encoder, cursor registers and keys register.
// TESTING (TICK_W=2 for sim)
//  1. Reset: all outputs 0; hold btn_n[4]=0 through reset release -> keys stays 0 until release and re-press.
//  2. Bounce: pulse btn_n[5] low for 1 tick x3 -> no event.
//     Hold low 4 ticks -> keys=6 for exactly 1 cycle, cursor unchanged.
//  3. Wrap: press RIGHT 8 times from x=0 -> x steps 1..7 then 0.
//     Press UP at y=0 -> y=7.
//  4. Repeat: hold LEFT 32+2*8 ticks from x=5 -> keys=3 three times (x=4,3,2).
//     Hold SET 64 ticks -> exactly one keys=5.
//  5. Simultaneous: assert UP and SET, debounced on the same tick -> keys=1 then keys=5 on consecutive cycles.
//     busy=1 for 2 cycles, y decremented once.
//  6. Reset mid-hold: drop reset while LEFT is repeating -> cursor 0,0 and repeat count cleared.
//     Still-held LEFT issues nothing until released.

Source files
------------

// File: rtl/life_keys_pkg.sv
// life_keys_pkg: key codes shared with the life core, plus the issue priority helper.
package life_keys_pkg;
  localparam int NBTN = 6;
  localparam logic [2:0] KEY_NONE  = 3'd0;
  localparam logic [2:0] KEY_UP    = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_LEFT  = 3'd3;
  localparam logic [2:0] KEY_RIGHT = 3'd4;
  localparam logic [2:0] KEY_SET   = 3'd5;
  localparam logic [2:0] KEY_RUN   = 3'd6;
  // Button i maps to code i+1; the lowest pending index wins.
  function automatic logic [2:0] key_of(input logic [NBTN-1:0] p);
    key_of = KEY_NONE;
    for (int i = NBTN - 1; i >= 0; i--)
      if (p[i]) key_of = 3'(i + 1);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: one button's synchroniser, debouncer, press edge and optional auto-repeat.
module key_debounce #(
  parameter int DEB_TICKS = 4,
  parameter int REP_DLY   = 32,
  parameter int REP_RATE  = 8,
  parameter bit REPEAT    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_n,
  output logic press_evt
);
  localparam int DW = $clog2(DEB_TICKS);
  localparam int RW = $clog2(REP_DLY + 1);
  logic s1, s2, smp, state, block, flip, rep_hit;
  logic [DW-1:0] deb;
  logic [RW-1:0] rep;
  assign smp = ~s2;
  assign flip = tick && (smp != state) && (deb == DW'(DEB_TICKS - 1));
  // A tick that releases the key must not also fire a repeat.
  assign rep_hit = REPEAT && tick && state && !flip && (rep == RW'(REP_DLY - 1));
  // block suppresses keys held across reset until they are seen released.
  assign press_evt = !block && ((flip && !state) || rep_hit);
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      state <= 1'b0;
      block <= 1'b1;
      deb   <= '0;
      rep   <= '0;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
      if (tick) begin
        deb <= (flip || smp == state) ? '0 : deb + 1'b1;
        if (flip) state <= ~state;
        if (!state && !smp) block <= 1'b0;
      end
      if (!state || flip) rep <= '0;
      else if (tick) rep <= rep_hit ? RW'(REP_DLY - REP_RATE) : rep + 1'b1;
    end
  end
endmodule

// File: rtl/life_keys.sv
// life_keys: front-panel controller turning debounced buttons into one-cycle key codes and cursor moves.
module life_keys
  import life_keys_pkg::*;
#(
  parameter int X         = 8,
  parameter int Y         = 8,
  parameter int LOG2X     = 3,
  parameter int LOG2Y     = 3,
  parameter int TICK_W    = 10,
  parameter int DEB_TICKS = 4,
  parameter int REP_DLY   = 32,
  parameter int REP_RATE  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBTN-1:0]  btn_n,
  output logic [2:0]       keys,
  output logic [LOG2X-1:0] cursor_x,
  output logic [LOG2Y-1:0] cursor_y,
  output logic             busy
);
  logic [TICK_W-1:0] pres;
  logic tick;
  logic [NBTN-1:0] evt, pending, grant, pend_nxt;
  logic [2:0] k;
  logic [LOG2X-1:0] x_n;
  logic [LOG2Y-1:0] y_n;
  assign tick = &pres;
  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    key_debounce #(
      .DEB_TICKS(DEB_TICKS),
      .REP_DLY  (REP_DLY),
      .REP_RATE (REP_RATE),
      .REPEAT   (i < 4)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .btn_n    (btn_n[i]),
      .press_evt(evt[i])
    );
  end
  // New events are OR-ed in after the grant clears, so a same-cycle set survives.
  assign grant    = pending & (~pending + 1'b1);
  assign pend_nxt = (pending & ~grant) | evt;
  assign k        = key_of(pending);
  assign x_n = k == KEY_LEFT  ? (cursor_x == '0 ? LOG2X'(X - 1) : cursor_x - 1'b1)
             : k == KEY_RIGHT ? (cursor_x == LOG2X'(X - 1) ? '0 : cursor_x + 1'b1)
             : cursor_x;
  assign y_n = k == KEY_UP    ? (cursor_y == '0 ? LOG2Y'(Y - 1) : cursor_y - 1'b1)
             : k == KEY_DOWN  ? (cursor_y == LOG2Y'(Y - 1) ? '0 : cursor_y + 1'b1)
             : cursor_y;
  always_ff @(posedge clk) begin
    if (!reset) begin
      pres     <= '0;
      pending  <= '0;
      busy     <= 1'b0;
      keys     <= KEY_NONE;
      cursor_x <= '0;
      cursor_y <= '0;
    end else begin
      pres     <= pres + 1'b1;
      pending  <= pend_nxt;
      busy     <= |pend_nxt;
      keys     <= k;
      cursor_x <= x_n;
      cursor_y <= y_n;
    end
  end
endmodule
